// File: rtl/sequenciador_matriz_pkg.sv
// Shared definitions for the 5x5 matrix load/readout sequencer.
// Holds the default matrix geometry, the datapath widths and the FSM state encoding.
package sequenciador_matriz_pkg;

    // Default geometry: 25 elements per matrix, matrix B stored right after matrix A.
    localparam int unsigned N_ELEM_PADRAO = 25;
    localparam int unsigned BASE_B_PADRAO = 25;

    // Datapath widths: 9-bit elements, 8-bit RAM address.
    localparam int unsigned DATA_W = 9;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [2:0] {
        OCIOSO,
        CARGA,
        LE_A,
        LE_B,
        CAPT_B,
        ENTREGA,
        FIM
    } estado_t;

endpackage

// File: rtl/sequenciador_matriz.sv
// Matrix load/readout sequencer.
// Loads A[0..N_ELEM-1] then B[0..N_ELEM-1] from a valid/ready input stream into an
// external synchronous-read RAM, then reads them back as (A[i], B[i]) pairs on a
// valid/ready output. The RAM lives in the parent; this block holds only the FSM
// and its counters.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   reset          - synchronous active-high reset
//   start          - begin a load+readout sequence (only looked at while idle)
//   dado_in        - element to load; dado_in_valido qualifies it
//   dado_in_pronto - high while the block accepts load elements
//   endereco       - shared RAM address
//   dado_entrada   - RAM write data
//   grava          - RAM write enable
//   dado_saida     - RAM read data, from the address presented one cycle earlier
//   par_a, par_b   - element pair A[i], B[i]; par_valido / par_pronto handshake
//   ocupado        - sequence in progress
//   concluido      - one-cycle pulse when the last pair has been taken
module sequenciador_matriz
    import sequenciador_matriz_pkg::*;
#(
    parameter int unsigned N_ELEM = N_ELEM_PADRAO,
    parameter int unsigned BASE_B = BASE_B_PADRAO
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dado_in,
    input  logic              dado_in_valido,
    output logic              dado_in_pronto,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] dado_entrada,
    output logic              grava,
    input  logic [DATA_W-1:0] dado_saida,
    output logic [DATA_W-1:0] par_a,
    output logic [DATA_W-1:0] par_b,
    output logic              par_valido,
    input  logic              par_pronto,
    output logic              ocupado,
    output logic              concluido
);

    // Last load index (covers both matrices) and last pair index.
    localparam logic [ADDR_W-1:0] K_ULT  = ADDR_W'(2 * N_ELEM - 1);
    localparam logic [ADDR_W-1:0] I_ULT  = ADDR_W'(N_ELEM - 1);
    localparam logic [ADDR_W-1:0] BASE_E = ADDR_W'(BASE_B);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] par_a_q, par_a_d;
    logic [DATA_W-1:0] par_b_q, par_b_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            k_q      <= '0;
            i_q      <= '0;
            par_a_q  <= '0;
            par_b_q  <= '0;
        end else begin
            estado_q <= estado_d;
            k_q      <= k_d;
            i_q      <= i_d;
            par_a_q  <= par_a_d;
            par_b_q  <= par_b_d;
        end
    end

    always_comb begin
        estado_d       = estado_q;
        k_d            = k_q;
        i_d            = i_q;
        par_a_d        = par_a_q;
        par_b_d        = par_b_q;
        dado_in_pronto = 1'b0;
        grava          = 1'b0;
        endereco       = '0;
        dado_entrada   = '0;
        par_valido     = 1'b0;
        ocupado        = 1'b1;
        concluido      = 1'b0;

        unique case (estado_q)
            OCIOSO: begin
                ocupado = 1'b0;
                if (start) begin
                    estado_d = CARGA;
                    k_d      = '0;
                end
            end

            CARGA: begin
                dado_in_pronto = 1'b1;
                grava          = dado_in_valido;
                endereco       = k_q;
                dado_entrada   = dado_in;
                if (dado_in_valido) begin
                    if (k_q == K_ULT) begin
                        // k parks at its last value instead of wrapping.
                        estado_d = LE_A;
                        i_d      = '0;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end

            // RAM read latency is one cycle: the address issued in LE_A comes back
            // during LE_B, the one issued in LE_B comes back during CAPT_B.
            LE_A: begin
                endereco = i_q;
                estado_d = LE_B;
            end

            LE_B: begin
                endereco = BASE_E + i_q;
                par_a_d  = dado_saida;
                estado_d = CAPT_B;
            end

            CAPT_B: begin
                par_b_d  = dado_saida;
                estado_d = ENTREGA;
            end

            ENTREGA: begin
                par_valido = 1'b1;
                if (par_pronto) begin
                    if (i_q == I_ULT) begin
                        estado_d = FIM;
                    end else begin
                        i_d      = i_q + 8'd1;
                        estado_d = LE_A;
                    end
                end
            end

            FIM: begin
                concluido = 1'b1;
                estado_d  = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign par_a = par_a_q;
    assign par_b = par_b_q;

endmodule

// File: tb/tb_sequenciador_matriz.sv
module tb_sequenciador_matriz;
    import sequenciador_matriz_pkg::*;

    localparam int N = N_ELEM_PADRAO;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] dado_in = '0;
    logic       dado_in_valido = 1'b0;
    logic       dado_in_pronto;
    logic [7:0] endereco;
    logic [8:0] dado_entrada;
    logic       grava;
    logic [8:0] dado_saida;
    logic [8:0] par_a, par_b;
    logic       par_valido;
    logic       par_pronto = 1'b1;
    logic       ocupado, concluido;

    int pass_cnt = 0;
    int tot_cnt = 0;

    always #5 clk = ~clk;

    sequenciador_matriz #(
        .N_ELEM(N_ELEM_PADRAO),
        .BASE_B(BASE_B_PADRAO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dado_in       (dado_in),
        .dado_in_valido(dado_in_valido),
        .dado_in_pronto(dado_in_pronto),
        .endereco      (endereco),
        .dado_entrada  (dado_entrada),
        .grava         (grava),
        .dado_saida    (dado_saida),
        .par_a         (par_a),
        .par_b         (par_b),
        .par_valido    (par_valido),
        .par_pronto    (par_pronto),
        .ocupado       (ocupado),
        .concluido     (concluido)
    );

    // Parent-level RAM: synchronous write, registered read address.
    logic [8:0] mem [0:255];
    logic [7:0] addr_r;
    always @(posedge clk) begin
        if (grava) mem[endereco] <= dado_entrada;
        addr_r <= endereco;
    end
    assign dado_saida = mem[addr_r];

    // Observation log, sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic clr_log = 1'b0;
    int wr_addr[$], wr_data[$], pa[$], pb[$], pcyc[$];
    int conc_cnt = 0, conc_cyc = 0, addr_max = 0, grava_bad = 0;

    always @(negedge clk) begin
        if (clr_log) begin
            wr_addr.delete(); wr_data.delete();
            pa.delete(); pb.delete(); pcyc.delete();
            conc_cnt <= 0; conc_cyc <= 0; addr_max <= 0; grava_bad <= 0;
        end else begin
            if (grava) begin
                wr_addr.push_back(int'(endereco));
                wr_data.push_back(int'(dado_entrada));
                if (!dado_in_valido) grava_bad <= grava_bad + 1;
            end
            if (par_valido && par_pronto) begin
                pa.push_back(int'(par_a));
                pb.push_back(int'(par_b));
                pcyc.push_back(cyc);
            end
            if (concluido) begin
                conc_cnt <= conc_cnt + 1;
                conc_cyc <= cyc;
            end
            if (int'(endereco) > addr_max) addr_max <= int'(endereco);
        end
    end

    function automatic int wr_errs(input int ofs);
        int e = 0;
        for (int j = 0; j < wr_addr.size(); j++)
            if (wr_addr[j] != j || wr_data[j] != j + 1 + ofs) e++;
        return e;
    endfunction

    function automatic int pair_errs();
        int e = 0;
        for (int j = 0; j < pa.size(); j++)
            if (pa[j] != j + 1 || pb[j] != j + 1 + N) e++;
        return e;
    endfunction

    function automatic int period_errs();
        int e = 0;
        for (int j = 1; j < pcyc.size(); j++)
            if (pcyc[j] - pcyc[j-1] != 4) e++;
        return e;
    endfunction

    // Drives one start + load + readout sequence; load element n carries n+1+ofs.
    task automatic run_seq(input bit gaps, input int ofs, input int stall_pair,
                           input int stall_len, input int abort_k, input int abort_pair,
                           input bit spur, output bit timeout, output bit aborted,
                           output int stalled, output int hold_err);
        int n, guard, pairs;
        bit fase, xfer, done;
        timeout = 0; aborted = 0; stalled = 0; hold_err = 0;
        clr_log = 1'b1; @(posedge clk); #1; clr_log = 1'b0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        n = 0; guard = 0; fase = 1'b1;
        while (n < 2 * N && !aborted && guard < 400) begin
            dado_in        = 9'(n + 1 + ofs);
            dado_in_valido = gaps ? fase : 1'b1;
            fase           = ~fase;
            start          = spur && (n == 5);
            xfer           = dado_in_valido && dado_in_pronto;
            if (xfer && n == abort_k) begin
                reset   = 1'b1;
                aborted = 1'b1;
            end
            @(posedge clk); #1;
            reset = 1'b0;
            if (xfer) n++;
            guard++;
        end
        dado_in_valido = 1'b0;
        start          = 1'b0;
        if (guard >= 400) timeout = 1;
        pairs = 0; done = 0; guard = 0;
        while (!aborted && !done && !timeout && guard < 1000) begin
            par_pronto = 1'b1;
            start      = 1'b0;
            if (par_valido) begin
                if (pairs + 1 == stall_pair && stalled < stall_len) begin
                    par_pronto = 1'b0;
                    stalled++;
                    if (par_a !== 9'(stall_pair) || par_b !== 9'(stall_pair + N)) hold_err++;
                end
                if (spur && pairs + 1 == 2) start = 1'b1;
                if (pairs + 1 == abort_pair) begin
                    reset   = 1'b1;
                    aborted = 1'b1;
                end
            end
            xfer = par_valido && par_pronto;
            done = concluido;
            @(posedge clk); #1;
            reset = 1'b0;
            if (xfer) pairs++;
            guard++;
        end
        start      = 1'b0;
        par_pronto = 1'b1;
        if (!aborted && !done) timeout = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tot_cnt++;
        if ({ocupado, concluido, grava, dado_in_pronto, par_valido, endereco, par_a, par_b} !== '0)
            $display("FAIL reset_outputs: got oc=%b co=%b gr=%b pr=%b pv=%b end=%0d a=%0d b=%0d want all 0",
                     ocupado, concluido, grava, dado_in_pronto, par_valido, endereco, par_a, par_b);
        else pass_cnt++;
        reset = 1'b0;
        @(posedge clk); #1;
        tot_cnt++;
        if (ocupado !== 1'b0) $display("FAIL idle_ocupado: got %b want 0", ocupado);
        else pass_cnt++;
    endtask

    task automatic test_nominal(input string nm, input bit gaps);
        bit to, ab; int st, he;
        run_seq(gaps, 0, 0, 0, -1, -1, 1'b0, to, ab, st, he);
        tot_cnt++;
        if (to !== 1'b0) $display("FAIL %s_timeout: got %b want 0", nm, to); else pass_cnt++;
        tot_cnt++;
        if (wr_addr.size() != 2 * N) $display("FAIL %s_wr_count: got %0d want %0d", nm, wr_addr.size(), 2 * N);
        else pass_cnt++;
        tot_cnt++;
        if (wr_errs(0) != 0) $display("FAIL %s_wr_content: got %0d bad want 0", nm, wr_errs(0));
        else pass_cnt++;
        tot_cnt++;
        if (grava_bad != 0) $display("FAIL %s_grava_invalid: got %0d want 0", nm, grava_bad);
        else pass_cnt++;
        tot_cnt++;
        if (pa.size() != N) $display("FAIL %s_pair_count: got %0d want %0d", nm, pa.size(), N);
        else pass_cnt++;
        tot_cnt++;
        if (pair_errs() != 0) $display("FAIL %s_pair_values: got %0d bad want 0", nm, pair_errs());
        else pass_cnt++;
        tot_cnt++;
        if (period_errs() != 0) $display("FAIL %s_pair_period: got %0d bad want 0", nm, period_errs());
        else pass_cnt++;
        tot_cnt++;
        if (conc_cnt != 1) $display("FAIL %s_concluido_pulses: got %0d want 1", nm, conc_cnt);
        else pass_cnt++;
        tot_cnt++;
        if (pcyc.size() == 0 || conc_cyc != pcyc[pcyc.size()-1] + 1)
            $display("FAIL %s_concluido_timing: got cyc %0d want last pair + 1", nm, conc_cyc);
        else pass_cnt++;
        tot_cnt++;
        if (addr_max > 2 * N - 1) $display("FAIL %s_addr_max: got %0d want <= %0d", nm, addr_max, 2 * N - 1);
        else pass_cnt++;
        tot_cnt++;
        if (ocupado !== 1'b0) $display("FAIL %s_end_idle: got ocupado %b want 0", nm, ocupado);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit to, ab; int st, he;
        run_seq(1'b0, 0, 3, 5, -1, -1, 1'b0, to, ab, st, he);
        tot_cnt++;
        if (to !== 1'b0) $display("FAIL bp_timeout: got %b want 0", to); else pass_cnt++;
        tot_cnt++;
        if (st != 5) $display("FAIL bp_stall_cycles: got %0d want 5", st); else pass_cnt++;
        tot_cnt++;
        if (he != 0) $display("FAIL bp_hold: got %0d bad cycles want 0", he); else pass_cnt++;
        tot_cnt++;
        if (pa.size() != N) $display("FAIL bp_pair_count: got %0d want %0d", pa.size(), N);
        else pass_cnt++;
        tot_cnt++;
        if (pair_errs() != 0) $display("FAIL bp_pair_values: got %0d bad want 0", pair_errs());
        else pass_cnt++;
        tot_cnt++;
        if (pcyc.size() < 3 || pcyc[2] - pcyc[1] != 9)
            $display("FAIL bp_stall_period: got %0d want 9", pcyc.size() < 3 ? -1 : pcyc[2] - pcyc[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit to, ab; int st, he, bad;
        run_seq(1'b0, 100, 0, 0, 30, -1, 1'b0, to, ab, st, he);
        tot_cnt++;
        if (ab !== 1'b1) $display("FAIL rst_load_reached: got %b want 1", ab); else pass_cnt++;
        tot_cnt++;
        if ({ocupado, concluido, grava, dado_in_pronto, par_valido, endereco, par_a, par_b} !== '0)
            $display("FAIL rst_load_outputs: got oc=%b gr=%b pr=%b end=%0d want all 0",
                     ocupado, grava, dado_in_pronto, endereco);
        else pass_cnt++;
        // Partial load must stay in RAM; locations past the abort point keep old data.
        bad = 0;
        for (int j = 0; j < 30; j++) if (mem[j] !== 9'(j + 101)) bad++;
        for (int j = 31; j < 2 * N; j++) if (mem[j] !== 9'(j + 1)) bad++;
        tot_cnt++;
        if (bad != 0) $display("FAIL rst_ram_retained: got %0d bad words want 0", bad); else pass_cnt++;
        run_seq(1'b0, 0, 0, 0, -1, 10, 1'b0, to, ab, st, he);
        tot_cnt++;
        if (ab !== 1'b1) $display("FAIL rst_pair_reached: got %b want 1", ab); else pass_cnt++;
        tot_cnt++;
        if ({ocupado, concluido, grava, dado_in_pronto, par_valido, endereco, par_a, par_b} !== '0)
            $display("FAIL rst_pair_outputs: got oc=%b pv=%b end=%0d a=%0d b=%0d want all 0",
                     ocupado, par_valido, endereco, par_a, par_b);
        else pass_cnt++;
        test_nominal("restart", 1'b0);
    endtask

    task automatic test_ignored_start();
        bit to, ab; int st, he;
        run_seq(1'b0, 0, 0, 0, -1, -1, 1'b1, to, ab, st, he);
        tot_cnt++;
        if (to !== 1'b0) $display("FAIL spur_timeout: got %b want 0", to); else pass_cnt++;
        tot_cnt++;
        if (wr_addr.size() != 2 * N || wr_errs(0) != 0)
            $display("FAIL spur_writes: got %0d writes %0d bad want %0d writes 0 bad",
                     wr_addr.size(), wr_errs(0), 2 * N);
        else pass_cnt++;
        tot_cnt++;
        if (pa.size() != N || pair_errs() != 0 || period_errs() != 0)
            $display("FAIL spur_pairs: got %0d pairs %0d bad %0d period errs want %0d 0 0",
                     pa.size(), pair_errs(), period_errs(), N);
        else pass_cnt++;
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        tot_cnt++;
        if (ocupado !== 1'b0 || dado_in_pronto !== 1'b0)
            $display("FAIL start_vs_reset: got ocupado %b pronto %b want 0 0", ocupado, dado_in_pronto);
        else pass_cnt++;
        @(posedge clk); #1;
        tot_cnt++;
        if (ocupado !== 1'b0) $display("FAIL start_vs_reset_idle: got %b want 0", ocupado);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_nominal("nominal", 1'b0);
        test_nominal("gaps", 1'b1);
        test_backpressure();
        test_reset_mid();
        test_ignored_start();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/sequenciador_matriz.md
SEQUENCIADOR_MATRIZ -- requirements
Module: sequenciador_matriz

Interface
REQ-001 SHALL have parameter N_ELEM, default 25, elements per 5x5 matrix.
REQ-002 SHALL have parameter BASE_B, default 25, RAM base address of matrix B (matrix A at 0).
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begin load+readout sequence; sampled only in OCIOSO.
REQ-006 SHALL have port dado_in, input, 9, load element, A[0..24] then B[0..24].
REQ-007 SHALL have port dado_in_valido, input, 1, dado_in valid.
REQ-008 SHALL have port dado_in_pronto, output, 1, block accepts dado_in.
REQ-009 SHALL have port endereco, output, 8, shared RAM address.
REQ-010 SHALL have port dado_entrada, output, 9, RAM write data.
REQ-011 SHALL have port grava, output, 1, RAM write enable.
REQ-012 SHALL have port dado_saida, input, 9, RAM read data: mem[endereco registered at previous edge].
REQ-013 SHALL have ports par_a, par_b, output, 9 each, element pair A[i], B[i].
REQ-014 SHALL have port par_valido, output, 1, par_a/par_b valid.
REQ-015 SHALL have port par_pronto, input, 1, consumer accepts pair.
REQ-016 SHALL have ports ocupado, output, 1, sequence in progress; concluido, output, 1, one-cycle completion pulse.

Function
REQ-017 States SHALL be OCIOSO, CARGA, LE_A, LE_B, CAPT_B, ENTREGA, FIM.
REQ-018 OCIOSO: start=1 -> CARGA with load index k=0 and ocupado=1 from next cycle; start ignored in all other states.
REQ-019 CARGA: dado_in_pronto=1; grava=dado_in_valido; endereco=k; dado_entrada=dado_in, all combinational from state/k.
REQ-020 Load transfer SHALL occur at each edge with dado_in_valido=1 in CARGA; k increments; transfer at k=2*N_ELEM-1 -> LE_A, i=0.
REQ-021 grava SHALL be 0 in every state except CARGA; endereco SHALL never exceed 2*N_ELEM-1.
REQ-022 LE_A: endereco=i -> LE_B, unconditional.
REQ-023 LE_B: endereco=BASE_B+i; par_a<=dado_saida at edge -> CAPT_B.
REQ-024 CAPT_B: par_b<=dado_saida at edge -> ENTREGA.
REQ-025 ENTREGA: par_valido=1; par_a/par_b stable until par_pronto=1 sampled at edge; then i<N_ELEM-1 -> LE_A, i+1; i=N_ELEM-1 -> FIM.
REQ-026 Minimum pair period SHALL be 4 cycles (par_pronto held 1); consumer stall SHALL extend ENTREGA indefinitely.
REQ-027 FIM: concluido=1 for exactly one cycle, ocupado=1 -> OCIOSO; ocupado=0 in OCIOSO.
REQ-028 Indices k (0..49), i (0..24) SHALL never wrap; no arithmetic beyond increment/add of BASE_B (8-bit).
REQ-029 dado_in_valido outside CARGA and par_pronto outside ENTREGA SHALL have no effect.

Reset
REQ-030 reset=1 at an edge SHALL force OCIOSO, k=i=0, par_a=par_b=0, par_valido=0, ocupado=0, concluido=0, grava=0, dado_in_pronto=0, endereco=0, regardless of state (mid-load, mid-readout included).
REQ-031 Reset SHALL NOT clear RAM contents; partial load data SHALL remain in RAM.
REQ-032 reset SHALL take priority over start in the same cycle.

Structure
REQ-033 Shared package SHALL hold state encoding, N_ELEM, BASE_B, data width 9, address width 8.
REQ-034 RAM (fluxo_ram) SHALL be instantiated outside, at the parent level; block contains FSM and counters only, no sub-module.

Verification
REQ-035 Nominal: start pulse, load 1..50 with dado_in_valido=1 continuous, par_pronto=1 -> 50 grava cycles to addresses 0..49, pairs (1,26)..(25,50) every 4 cycles, concluido one pulse after pair 25.
REQ-036 Load gaps: dado_in_valido toggling 1/0 -> grava only on valid cycles, addresses contiguous 0..49, same pairs.
REQ-037 Backpressure: par_pronto=0 for 5 cycles on pair 3 -> par_a=3, par_b=28 held, par_valido=1 throughout, no skipped/duplicated pair.
REQ-038 Reset mid-operation: reset at k=30, then at pair 10 -> all outputs zero next cycle, OCIOSO; restart reproduces full nominal result.
REQ-039 Ignored start: start pulses during CARGA and ENTREGA -> no state change; start and reset same cycle -> OCIOSO.
